// File: rtl/decode_issue_sched.sv
// Fetch-to-decode issue queue with short-forward-branch (SFO) shadow tracking.
// Shadow FSM, counter and cancel pulse exist only when DECODE_SFO_EN is defined.
module decode_issue_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SFO_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fq_valid_i,
  output logic        fq_ready_o,
  input  logic [31:0] fq_instr_i,
  input  logic [31:0] fq_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  input  logic        is_br_i,
  input  logic        shadowable_i,
  input  logic [12:0] br_off_i,
  output logic        under_shadow_o,
  output logic        sfo_cancel_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [31:0]     r_instr [DEPTH];
  logic [31:0]     r_pc    [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_deq;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) &&
                   (r_wptr[IdxW-1:0] == r_rptr[IdxW-1:0]);

  // Flush discards both handshakes of its cycle.
  assign w_enq = fq_valid_i & ~w_full & ~flush;
  assign w_deq = dec_ready_i & ~w_empty & ~flush;

  assign fq_ready_o  = ~w_full;
  assign dec_valid_o = ~w_empty;
  assign dec_instr_o = r_instr[r_rptr[IdxW-1:0]];
  assign dec_pc_o    = r_pc[r_rptr[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PtrW'(1);
      if (w_deq) r_rptr <= r_rptr + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !rst) begin
      r_instr[r_wptr[IdxW-1:0]] <= fq_instr_i;
      r_pc[r_wptr[IdxW-1:0]]    <= fq_pc_i;
    end
  end

`ifdef DECODE_SFO_EN
  localparam int unsigned CntW   = $clog2(SFO_MAX + 1);
  localparam int          OffMax = 4 * (int'(SFO_MAX) + 1);

  typedef enum logic {StIdle, StShadow} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [CntW-1:0]    w_cnt_next;
  logic               r_cancel;
  logic               w_cancel_next;
  logic signed [31:0] w_off;
  logic               w_sfo_open;

  assign w_off      = {{19{br_off_i[12]}}, br_off_i};
  assign w_sfo_open = is_br_i && (w_off >= 32'sd8) && (w_off <= OffMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_cancel <= w_cancel_next;
    end
  end

  // Counter holds the number of shadowed instructions still to be issued.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_cancel_next = 1'b0;
    if (w_deq) begin
      case (r_state)
        StIdle: begin
          if (w_sfo_open) begin
            w_state_next = StShadow;
            w_cnt_next   = CntW'(br_off_i[12:2] - 11'd1);
          end
        end
        StShadow: begin
          if (shadowable_i) begin
            w_cnt_next = r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) w_state_next = StIdle;
          end else begin
            w_state_next  = StIdle;
            w_cnt_next    = '0;
            w_cancel_next = 1'b1;
          end
        end
        default: begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end
      endcase
    end
    if (flush) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
    end
  end

  assign under_shadow_o = (r_state == StShadow) & ~w_empty;
  assign sfo_cancel_o   = r_cancel;
`else
  logic w_unused_sfo;
  assign w_unused_sfo   = ^{is_br_i, shadowable_i, br_off_i};
  assign under_shadow_o = 1'b0;
  assign sfo_cancel_o   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue_sched.sv
// Self-checking bench for decode_issue_sched: queue/shadow reference model plus directed vectors.
// Expectations for shadow outputs follow DECODE_SFO_EN.
module tb_decode_issue_sched;

  localparam int DEPTH   = 4;
  localparam int SFO_MAX = 4;
`ifdef DECODE_SFO_EN
  localparam bit SfoEn = 1'b1;
`else
  localparam bit SfoEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, fq_valid_i, dec_ready_i, is_br_i, shadowable_i;
  logic        fq_ready_o, dec_valid_o, under_shadow_o, sfo_cancel_o;
  logic [31:0] fq_instr_i, fq_pc_i, dec_instr_o, dec_pc_o;
  logic [12:0] br_off_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  decode_issue_sched #(.DEPTH(DEPTH), .SFO_MAX(SFO_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fq_valid_i(fq_valid_i), .fq_ready_o(fq_ready_o),
    .fq_instr_i(fq_instr_i), .fq_pc_i(fq_pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
    .is_br_i(is_br_i), .shadowable_i(shadowable_i), .br_off_i(br_off_i),
    .under_shadow_o(under_shadow_o), .sfo_cancel_o(sfo_cancel_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: entry list plus count of instructions left in the open shadow.
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t mq[$];
  int   m_left   = 0;
  bit   m_cancel = 1'b0;
  int   m_off;
  bit   m_acc, m_enq;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_left   = 0;
      m_cancel = 1'b0;
    end else begin
      m_cancel = 1'b0;
      if (flush) begin
        mq.delete();
        m_left = 0;
      end else begin
        m_acc = (mq.size() > 0) && dec_ready_i;
        m_enq = fq_valid_i && (mq.size() < DEPTH);
        if (m_acc) begin
          void'(mq.pop_front());
          if (SfoEn) begin
            if (m_left > 0) begin
              if (shadowable_i) m_left = m_left - 1;
              else begin
                m_left   = 0;
                m_cancel = 1'b1;
              end
            end else if (is_br_i) begin
              m_off = int'($signed(br_off_i));
              if (m_off >= 8 && m_off <= 4 * (SFO_MAX + 1)) m_left = m_off / 4 - 1;
            end
          end
        end
        if (m_enq) mq.push_back({fq_instr_i, fq_pc_i});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model fq_ready", 32'(fq_ready_o), 32'(mq.size() < DEPTH));
      check("model dec_valid", 32'(dec_valid_o), 32'(mq.size() > 0));
      check("model under_shadow", 32'(under_shadow_o), 32'(SfoEn && m_left > 0 && mq.size() > 0));
      check("model sfo_cancel", 32'(sfo_cancel_o), 32'(m_cancel));
      if (mq.size() > 0) begin
        check("model dec_instr", dec_instr_o, mq[0].instr);
        check("model dec_pc", dec_pc_o, mq[0].pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    fq_valid_i = 1'b1;
    fq_instr_i = instr;
    fq_pc_i    = pc;
    step();
    fq_valid_i = 1'b0;
  endtask

  task automatic issue(input logic br, input logic shd, input logic [12:0] off,
                       input logic exp_under, input string name);
    is_br_i      = br;
    shadowable_i = shd;
    br_off_i     = off;
    dec_ready_i  = 1'b1;
    check({name, " valid"}, 32'(dec_valid_o), 32'd1);
    check({name, " under"}, 32'(under_shadow_o), 32'(exp_under));
    step();
    dec_ready_i  = 1'b0;
    is_br_i      = 1'b0;
    shadowable_i = 1'b0;
    br_off_i     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fq_valid_i = 1'b0; dec_ready_i = 1'b0;
    is_br_i = 1'b0; shadowable_i = 1'b0; br_off_i = '0;
    fq_instr_i = '0; fq_pc_i = '0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset fq_ready", 32'(fq_ready_o), 32'd1);
    check("reset dec_valid", 32'(dec_valid_o), 32'd0);
    check("reset under", 32'(under_shadow_o), 32'd0);
    check("reset cancel", 32'(sfo_cancel_o), 32'd0);

    // Fill then drain
    for (int i = 0; i < 4; i++) push(32'h0000_0013, 32'h100 + 32'(4 * i));
    check("fill ready low", 32'(fq_ready_o), 32'd0);
    dec_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain valid", 32'(dec_valid_o), 32'd1);
      check("drain pc", dec_pc_o, 32'h100 + 32'(4 * i));
      step();
    end
    check("drain empty", 32'(dec_valid_o), 32'd0);

    // Streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      fq_valid_i = 1'b1;
      fq_instr_i = 32'h1000 + 32'(i);
      fq_pc_i    = 32'h200 + 32'(4 * i);
      if (i >= 1) check("stream pc", dec_pc_o, 32'h200 + 32'(4 * (i - 1)));
      step();
    end
    fq_valid_i = 1'b0;
    check("stream last pc", dec_pc_o, 32'h24C);
    step();
    check("stream empty", 32'(dec_valid_o), 32'd0);
    dec_ready_i = 1'b0;

    // Shadow opens for two instructions and closes
    push(32'h0000_0463, 32'h300);
    for (int i = 1; i < 4; i++) push(32'h0000_0013, 32'h300 + 32'(4 * i));
    issue(1'b1, 1'b0, 13'd12, 1'b0, "open br");
    issue(1'b0, 1'b1, 13'd0, SfoEn, "open alu1");
    issue(1'b0, 1'b1, 13'd0, SfoEn, "open alu2");
    issue(1'b0, 1'b1, 13'd0, 1'b0, "open alu3");
    check("open no cancel", 32'(sfo_cancel_o), 32'd0);

    // Non-shadowable load cancels
    for (int i = 0; i < 4; i++) push(32'h0000_0013, 32'h400 + 32'(4 * i));
    issue(1'b1, 1'b0, 13'd16, 1'b0, "cancel br");
    issue(1'b0, 1'b1, 13'd0, SfoEn, "cancel alu");
    issue(1'b0, 1'b0, 13'd0, SfoEn, "cancel load");
    check("cancel pulse", 32'(sfo_cancel_o), 32'(SfoEn));
    issue(1'b0, 1'b1, 13'd0, 1'b0, "cancel after");
    check("cancel one cycle", 32'(sfo_cancel_o), 32'd0);

    // Out-of-range offsets
    for (int i = 0; i < 4; i++) push(32'h0000_0063, 32'h500 + 32'(4 * i));
    issue(1'b1, 1'b0, 13'd4, 1'b0, "oor +4");
    issue(1'b1, 1'b0, 13'h1FF8, 1'b0, "oor -8");
    issue(1'b1, 1'b0, 13'd24, 1'b0, "oor +24");
    issue(1'b0, 1'b1, 13'd0, 1'b0, "oor alu");

    // Flush beats a concurrent enqueue and the open shadow
    for (int i = 0; i < 4; i++) push(32'h0000_0013, 32'h600 + 32'(4 * i));
    issue(1'b1, 1'b0, 13'd12, 1'b0, "flush br");
    check("flush shadow open", 32'(under_shadow_o), 32'(SfoEn));
    flush = 1'b1; fq_valid_i = 1'b1; fq_pc_i = 32'hDEAD; dec_ready_i = 1'b1; shadowable_i = 1'b1;
    step();
    flush = 1'b0; fq_valid_i = 1'b0; dec_ready_i = 1'b0; shadowable_i = 1'b0;
    check("flush valid", 32'(dec_valid_o), 32'd0);
    check("flush under", 32'(under_shadow_o), 32'd0);
    check("flush ready", 32'(fq_ready_o), 32'd1);
    step();
    check("flush no entry", 32'(dec_valid_o), 32'd0);

    // Reset beats a concurrent enqueue and the open shadow
    for (int i = 0; i < 4; i++) push(32'h0000_0013, 32'h700 + 32'(4 * i));
    issue(1'b1, 1'b0, 13'd12, 1'b0, "rst br");
    rst = 1'b1; fq_valid_i = 1'b1; dec_ready_i = 1'b1;
    step();
    rst = 1'b0; fq_valid_i = 1'b0; dec_ready_i = 1'b0;
    check("rst ready", 32'(fq_ready_o), 32'd1);
    check("rst valid", 32'(dec_valid_o), 32'd0);
    check("rst under", 32'(under_shadow_o), 32'd0);
    check("rst cancel", 32'(sfo_cancel_o), 32'd0);

    // Reset on the load-accept edge suppresses the pending cancel
    push(32'h0000_0063, 32'h800);
    push(32'h0000_2003, 32'h804);
    issue(1'b1, 1'b0, 13'd8, 1'b0, "rstc br");
    rst = 1'b1; dec_ready_i = 1'b1; shadowable_i = 1'b0;
    step();
    rst = 1'b0; dec_ready_i = 1'b0;
    check("rstc cancel", 32'(sfo_cancel_o), 32'd0);
    check("rstc valid", 32'(dec_valid_o), 32'd0);

    // Flush during the cancel pulse: pulse completes, queue clears
    for (int i = 0; i < 4; i++) push(32'h0000_0013, 32'h900 + 32'(4 * i));
    issue(1'b1, 1'b0, 13'd16, 1'b0, "fc br");
    issue(1'b0, 1'b1, 13'd0, SfoEn, "fc alu");
    issue(1'b0, 1'b0, 13'd0, SfoEn, "fc load");
    check("fc pulse", 32'(sfo_cancel_o), 32'(SfoEn));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fc pulse end", 32'(sfo_cancel_o), 32'd0);
    check("fc valid", 32'(dec_valid_o), 32'd0);
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
